// File: rtl/pll_freq_ctrl.sv
// Frequency-control stage of the simple PLL: counts oscillator edges over a fixed
// reference window and integrates the count error into a saturating supply code.
module pll_freq_ctrl #(
   parameter int WINDOW       = 1024,
   parameter int CNT_W        = 16,
   parameter int CODE_W       = 10,
   parameter int CODE_INIT    = 512,
   parameter int GAIN_SHIFT   = 2,
   parameter int LOCK_TOL     = 2,
   parameter int LOCK_WINDOWS = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              vco_in,
   input  logic [CNT_W-1:0]  target_cnt,
   output logic [CODE_W-1:0] vdd_code,
   output logic [CNT_W-1:0]  meas_cnt,
   output logic              meas_valid,
   output logic              locked
);
   // state   | meaning
   // IDLE    | loop disabled, counters cleared, waiting for en
   // MEASURE | counting oscillator edges over WINDOW clk cycles
   // UPDATE  | single cycle: integral step, publish measurement, evaluate lock
   typedef enum logic [1:0] {IDLE, MEASURE, UPDATE} state_t;

   localparam int WIN_W  = $clog2(WINDOW);
   localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);
   localparam int SUM_W  = ((CODE_W > CNT_W + 1) ? CODE_W : CNT_W + 1) + 2;

   localparam logic [WIN_W-1:0]        win_last = WIN_W'(WINDOW - 1);
   localparam logic [GOOD_W-1:0]       good_max = GOOD_W'(LOCK_WINDOWS);
   localparam logic [CNT_W-1:0]        cnt_max  = '1;
   localparam logic signed [CNT_W:0]   tol_pos  = (CNT_W + 1)'(LOCK_TOL);
   localparam logic signed [CNT_W:0]   tol_neg  = -tol_pos;
   localparam logic signed [SUM_W-1:0] code_max = SUM_W'((2 ** CODE_W) - 1);

   state_t                  state;
   logic [SYNC_STAGES-1:0]  sync;
   logic                    prev;
   logic                    vco_edge;
   logic [WIN_W-1:0]        win_cnt;
   logic [CNT_W-1:0]        edge_cnt;
   logic [GOOD_W-1:0]       good_cnt;
   logic signed [CNT_W:0]   err;
   logic signed [CNT_W:0]   delta;
   logic signed [SUM_W-1:0] sum;
   logic [CODE_W-1:0]       code_next;
   logic                    in_tol;

   assign vco_edge = sync[SYNC_STAGES-1] & ~prev;

   // Sum is wide enough that vdd_code plus any delta cannot wrap before clamping.
   always_comb begin
      code_next = vdd_code;
      err       = $signed({1'b0, target_cnt}) - $signed({1'b0, edge_cnt});
      delta     = err >>> GAIN_SHIFT;
      sum       = $signed({{(SUM_W - CODE_W){1'b0}}, vdd_code})
                + $signed({{(SUM_W - CNT_W - 1){delta[CNT_W]}}, delta});
      in_tol    = (err <= tol_pos) && (err >= tol_neg);
      if (sum[SUM_W-1])
         code_next = '0;
      else if (sum > code_max)
         code_next = '1;
      else
         code_next = sum[CODE_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync       <= '0;
         prev       <= 1'b0;
         state      <= IDLE;
         win_cnt    <= '0;
         edge_cnt   <= '0;
         good_cnt   <= '0;
         vdd_code   <= CODE_W'(CODE_INIT);
         meas_cnt   <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
      end else begin
         sync       <= {sync[SYNC_STAGES-2:0], vco_in};
         prev       <= sync[SYNC_STAGES-1];
         meas_valid <= 1'b0;
         if (!en) begin
            // Disabling abandons any partial window but keeps the last code.
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
            good_cnt <= '0;
            locked   <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state    <= MEASURE;
                  win_cnt  <= '0;
                  edge_cnt <= '0;
               end
               MEASURE: begin
                  if (vco_edge && (edge_cnt != cnt_max))
                     edge_cnt <= edge_cnt + 1'b1;
                  if (win_cnt == win_last)
                     state <= UPDATE;
                  else
                     win_cnt <= win_cnt + 1'b1;
               end
               UPDATE: begin
                  vdd_code   <= code_next;
                  meas_cnt   <= edge_cnt;
                  meas_valid <= 1'b1;
                  if (in_tol) begin
                     if (good_cnt != good_max)
                        good_cnt <= good_cnt + 1'b1;
                     locked <= (good_cnt >= good_max - 1'b1);
                  end else begin
                     good_cnt <= '0;
                     locked   <= 1'b0;
                  end
                  state    <= MEASURE;
                  win_cnt  <= '0;
                  edge_cnt <= '0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pll_freq_ctrl.sv
// Scoreboard bench for pll_freq_ctrl: a planned oscillator waveform feeds both the
// DUT and an arithmetic window/integrator model; a monitor checks every meas_valid.
module tb_pll_freq_ctrl;
   localparam int WINDOW       = 1024;
   localparam int SYNC_STAGES  = 2;
   localparam int CODE_INIT    = 512;
   localparam int CODE_MAX     = 1023;
   localparam int GAIN         = 4;
   localparam int LOCK_TOL     = 2;
   localparam int LOCK_WINDOWS = 4;
   localparam int MAXC         = 65536;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        vco_in;
   logic [15:0] target_cnt;
   logic [9:0]  vdd_code;
   logic [15:0] meas_cnt;
   logic        meas_valid;
   logic        locked;

   pll_freq_ctrl dut (
      .clk(clk), .rst(rst), .en(en), .vco_in(vco_in), .target_cnt(target_cnt),
      .vdd_code(vdd_code), .meas_cnt(meas_cnt), .meas_valid(meas_valid), .locked(locked)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int cnt; int vdd; int lck;} exp_t;
   exp_t sb[$];

   int cyc = 0;
   int nchk = 0;
   int nerr = 0;
   bit vplan [0:MAXC-1];
   int m_vdd = CODE_INIT;
   int m_good = 0;
   int m_lck = 0;
   int next_upd = 0;

   // cyc counts rising clk edges; vplan[p] is the vco_in level sampled at edge p
   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int req);
      nchk++;
      if (act != req) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      vco_in = (cyc + 1 < MAXC) ? vplan[cyc+1] : 1'b0;
   endtask

   // kind 0: constant low, 1: constant high, 2: square wave of period per
   function automatic void plan(input int from, input int to, input int kind,
                                input int per, input int ph);
      for (int c = from; c <= to && c < MAXC; c++) begin
         if (kind == 0)      vplan[c] = 1'b0;
         else if (kind == 1) vplan[c] = 1'b1;
         else                vplan[c] = (((c + ph) % per) < per / 2);
      end
   endfunction

   // A rise sampled at edge p is counted at edge p+SYNC_STAGES; window covers [a,b]
   function automatic int exp_count(input int a, input int b);
      int n = 0;
      for (int p = a - SYNC_STAGES; p <= b - SYNC_STAGES; p++)
         if (p >= 1 && vplan[p] && !vplan[p-1]) n++;
      return n;
   endfunction

   task automatic window(input int tgt);
      int cnt, err, d;
      target_cnt = 16'(tgt);
      cnt = exp_count(next_upd - WINDOW, next_upd - 1);
      err = tgt - cnt;
      d = err / GAIN;
      if (err < 0 && (err % GAIN) != 0) d = d - 1;
      m_vdd = m_vdd + d;
      if (m_vdd < 0) m_vdd = 0;
      if (m_vdd > CODE_MAX) m_vdd = CODE_MAX;
      if (err <= LOCK_TOL && err >= -LOCK_TOL)
         m_good = (m_good < LOCK_WINDOWS) ? m_good + 1 : LOCK_WINDOWS;
      else
         m_good = 0;
      m_lck = (m_good == LOCK_WINDOWS) ? 1 : 0;
      sb.push_back('{next_upd, cnt, m_vdd, m_lck});
      while (cyc < next_upd) tick();
      next_upd = next_upd + WINDOW + 1;
   endtask

   task automatic start_en();
      tick();
      en = 1'b1;
      next_upd = cyc + 1 + WINDOW + 1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (meas_valid === 1'b1) begin
         if (sb.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_valid: got meas_valid=1 expected 0 (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("valid_cycle", cyc, e.cyc);
            check("meas_cnt", int'(meas_cnt), e.cnt);
            check("vdd_code", int'(vdd_code), e.vdd);
            check("locked", int'(locked), e.lck);
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; vco_in = 1'b0; target_cnt = '0;
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         check("rst_vdd", int'(vdd_code), CODE_INIT);
         check("rst_meas", int'(meas_cnt), 0);
         check("rst_valid", int'(meas_valid), 0);
         check("rst_locked", int'(locked), 0);
      end

      // steady period-8 oscillator: 128 edges per window
      plan(cyc + 2, MAXC - 1, 2, 8, 0);
      repeat (20) tick();
      start_en();
      repeat (5) window(128);
      window(127);
      window(200);
      repeat (4) window(128);

      // drop en at window cycle 500 while locked
      while (cyc < next_upd - WINDOW + 499) tick();
      check("locked_before_drop", int'(locked), 1);
      en = 1'b0;
      m_good = 0;
      m_lck = 0;
      tick();
      check("drop_locked", int'(locked), 0);
      check("drop_vdd", int'(vdd_code), m_vdd);
      for (int i = 0; i < 30; i++) begin
         tick();
         check("idle_valid", int'(meas_valid), 0);
         check("idle_vdd", int'(vdd_code), m_vdd);
      end
      start_en();
      window(128);

      // constant low, single pulse at window cycle 0, then constant high
      plan(cyc + 2, next_upd + 10, 0, 1, 0);
      window($urandom_range(0, 3));
      plan(next_upd - WINDOW, next_upd - WINDOW + 1, 1, 1, 0);
      plan(next_upd - WINDOW + 2, next_upd - 3, 0, 1, 0);
      plan(next_upd - 2, next_upd + WINDOW + 20, 1, 1, 0);
      window($urandom_range(0, 3));
      window($urandom_range(0, 3));

      for (int k = 0; k < 10; k++) begin
         int per, tgt, c;
         per = $urandom_range(3, 40);
         plan(cyc + 2, next_upd + 4, 2, per, $urandom_range(0, per - 1));
         c = exp_count(next_upd - WINDOW, next_upd - 1);
         if ($urandom_range(0, 1) == 1) tgt = c + $urandom_range(0, 6) - 3;
         else tgt = $urandom_range(0, 600);
         if (tgt < 0) tgt = 0;
         window(tgt);
      end

      // reset while enabled, then drive the code to both clamps
      rst = 1'b1;
      plan(cyc + 2, cyc + 12, 0, 1, 0);
      plan(cyc + 13, MAXC - 1, 2, 8, 0);
      tick();
      tick();
      check("rst2_vdd", int'(vdd_code), CODE_INIT);
      check("rst2_meas", int'(meas_cnt), 0);
      check("rst2_valid", int'(meas_valid), 0);
      check("rst2_locked", int'(locked), 0);
      m_vdd = CODE_INIT;
      m_good = 0;
      m_lck = 0;
      rst = 1'b0;
      next_upd = cyc + WINDOW + 2;
      repeat (15) window(0);
      check("sat_low_not_yet", (int'(vdd_code) > 0) ? 1 : 0, 1);
      window(0);
      check("sat_low_16th", int'(vdd_code), 0);
      repeat (2) window(0);
      check("sat_low_hold", int'(vdd_code), 0);
      plan(cyc + 2, MAXC - 1, 0, 1, 0);
      repeat (2) window(65535);
      check("sat_high", int'(vdd_code), CODE_MAX);

      repeat (5) tick();
      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/pll_freq_ctrl.md
Name: pll_freq_ctrl

Overview:
- Digital frequency-control stage directly downstream of the ring-oscillator model in the simple PLL; closes the loop back to its supply input.
- Counts rising edges of the oscillator output over a fixed window of reference clocks and compares the count to a target.
- Updates a saturating integral control code; the bench scales this code to the oscillator's real-valued vdd input.
- Flags lock after consecutive in-tolerance windows.

Parameters:
- WINDOW, 1024: MEASURE length in clk cycles (>=2).
- CNT_W, 16: width of edge counter, target and meas_cnt.
- CODE_W, 10: width of control code.
- CODE_INIT, 512: vdd_code value after reset.
- GAIN_SHIFT, 2: arithmetic right shift applied to error (integral gain 2^-GAIN_SHIFT).
- LOCK_TOL, 2: maximum |error| counted as in tolerance.
- LOCK_WINDOWS, 4: consecutive in-tolerance windows required to assert locked.
- SYNC_STAGES, 2: synchronizer flops on vco_in (>=2).

Ports:
- clk  input  1  reference clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  loop enable.
- vco_in  input  1  oscillator output, asynchronous to clk; frequency < clk/2.
- target_cnt  input  CNT_W  desired edges per window (unsigned).
- vdd_code  output  CODE_W  control code to oscillator supply (unsigned).
- meas_cnt  output  CNT_W  edge count of last completed window.
- meas_valid  output  1  one-cycle pulse when meas_cnt/vdd_code update.
- locked  output  1  lock indicator.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- Reset: vdd_code=CODE_INIT; meas_cnt=0; meas_valid=0; locked=0; good-window count=0; synchronizer flops=0; state=IDLE. Reset overrides en in the same cycle.
- Edge detect:
  - vco_in passes through SYNC_STAGES flops, then one previous-value flop.
  - edge = sync_out & ~prev.
  - A vco_in rising edge produces edge exactly SYNC_STAGES+1 cycles later.
  - Synchronizer runs in every state.
- States:
  - IDLE: counters cleared. Go to MEASURE when en=1.
  - MEASURE: window counter runs 0..WINDOW-1. Edge counter increments on edge and saturates at 2^CNT_W-1. After the cycle with window counter = WINDOW-1, go to UPDATE. If en=0, go to IDLE and discard the partial window.
  - UPDATE: lasts exactly one cycle. Edges in this cycle are discarded.
    - err = target_cnt - edge_count, signed CNT_W+1 bits.
    - delta = err >>> GAIN_SHIFT (arithmetic, rounds toward -inf).
    - vdd_code <= clamp(vdd_code + delta, 0, 2^CODE_W-1). Compute at a width that cannot overflow.
    - meas_cnt <= edge_count; meas_valid <= 1 for one cycle.
    - Next state: MEASURE with counters cleared if en=1, else IDLE.
- Output timing:
  - Outputs are registered; the UPDATE results are visible the cycle after UPDATE.
  - With en held high, meas_valid period is WINDOW+1 cycles.
  - The first meas_valid comes WINDOW+2 cycles after the first cycle en=1 is sampled in IDLE.
- Lock (evaluated in UPDATE):
  - If |err| <= LOCK_TOL: good count increments, saturating at LOCK_WINDOWS.
  - Otherwise: good count clears and locked drops with that same update.
  - locked=1 whenever good count = LOCK_WINDOWS.
- en=0 in any state:
  - locked and good count clear next cycle; meas_valid stays 0.
  - vdd_code and meas_cnt are held.
- Re-enable starts a fresh full window; vdd_code is retained.
- target_cnt is sampled only in UPDATE; changes mid-window have no other effect.
- Error sign: a count above target means the oscillator is too fast, so vdd_code decreases.

Test Plan:
- Reset with en=0: vdd_code=512, meas_cnt=0, meas_valid=0, locked=0. Hold 50 cycles, outputs unchanged.
- vco_in period 8 clk, target_cnt=128, en=1: meas_cnt=128, vdd_code stays 512, meas_valid every 1025 cycles. locked rises with the 4th meas_valid.
- Same vco_in, target_cnt=200: first update err=72, delta=18, vdd_code=530, locked=0. target_cnt=127 after lock: err=-1 (in tol), delta=-1, vdd_code=511, locked stays 1.
- Saturation:
  - target_cnt=0 with vco_in period 8: delta=-32 per window; vdd_code reaches 0 at the 16th update and stays 0.
  - target_cnt=65535 with vco_in constant: vdd_code climbs to 1023 and clamps.
- en dropped at window cycle 500 after lock: no meas_valid, locked=0 next cycle, vdd_code held. Re-raise en: next meas_valid exactly 1026 cycles later.
- vco_in held constant 0 or 1 through a window: meas_cnt=0. A single vco_in pulse at window cycle 0: meas_cnt=1 (edge lands SYNC_STAGES+1 cycles later).
